// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial add/subtract controller. A single 1-bit full-adder cell is
//   time-shared across the operand width: operands are shifted through it
//   LSB-first, one bit per clock, with the carry held in a flop. Operations
//   enter and results leave over ready/valid handshakes.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/op present            in_ready   operation can be accepted
//   op_a       operand A                      op_b       operand B
//   sub        0: A+B, 1: A-B
//   out_valid  result present                 out_ready  consumer takes result
//   sum        result (meaningful while out_valid=1)
//   cout       final carry (sub: 1 = no borrow)
//   overflow   signed overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic [CntW-1:0]   r_cnt;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;

    // Shared full-adder cell
    logic w_s;
    logic w_co;

    assign w_s  = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_co = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        // Subtraction as A + ~B + 1: invert B, seed carry with 1
                        r_a     <= op_a;
                        r_b     <= sub ? ~op_b : op_b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    if (r_cnt == LastBit) begin
                        // r_carry is the carry into the MSB on this bit
                        r_cout  <= w_co;
                        r_ovf   <= r_carry ^ w_co;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed cases plus randomized ops checked
// against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for carry, signed for overflow
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int ua;
        int ub;
        int sa;
        int sb;
        int ur;
        int sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = s ? ua - ub : ua + ub;
        sr = s ? sa - sb : sa + sb;
        e_sum  = W'(ur);
        e_cout = s ? (ua >= ub) : (ur >= (1 << W));
        e_ovf  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    endtask

    // Present an op (called near a negedge) and complete the accept edge
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        model(a, b, s);
        chk("in_ready_before_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from accept to out_valid, scrambling inputs meanwhile
    task automatic wait_result();
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 4 * W) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            op_a = W'($urandom);
            op_b = W'($urandom);
            sub  = 1'($urandom);
        end
        chk("latency", cnt, W);
    endtask

    // At a negedge with the result up: check it, stall, then hand it off
    task automatic finish_op(input int stall, input logic hold,
                             input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
        chk("out_valid", out_valid, 1);
        chk("in_ready_done", in_ready, 0);
        chk("sum", sum, e_sum);
        chk("cout", cout, e_cout);
        chk("overflow", overflow, e_ovf);
        if (hold) begin
            op_a     = na;
            op_b     = nb;
            sub      = ns;
            in_valid = 1'b1;
        end
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_hold", {out_valid, in_ready, cout, overflow, sum},
                {1'b1, 1'b0, e_cout, e_ovf, e_sum});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("after_handshake", {out_valid, in_ready}, 2'b01);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int stall);
        start_op(a, b, s);
        wait_result();
        finish_op(stall, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        int seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        #1;
        chk("reset_outputs", {out_valid, cout, overflow, sum}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);

        // Directed arithmetic cases
        do_op(8'h5A, 8'h3C, 1'b0, 0);
        chk("model_5a_3c", {e_sum, e_cout, e_ovf}, {8'h96, 1'b0, 1'b1});
        do_op(8'hFF, 8'h01, 1'b0, 1);
        do_op(8'h10, 8'h20, 1'b1, 0);
        do_op(8'h80, 8'h01, 1'b1, 2);

        // Long stall with a held in_valid; accept only after the out handshake
        start_op(8'h7F, 8'h01, 1'b0);
        wait_result();
        finish_op(5, 1'b1, 8'h11, 8'h22, 1'b0);
        start_op(8'h11, 8'h22, 1'b0);
        wait_result();
        finish_op(0, 1'b0, '0, '0, 1'b0);

        // Reset mid-RUN after bit 3
        start_op(8'hAA, 8'h55, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_state", {out_valid, in_ready, cout, overflow, sum},
            {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        #1;
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        chk("no_result_after_abort", seen_valid, 0);
        do_op(8'h01, 8'h01, 1'b0, 0);
        chk("model_01_01", e_sum, 8'h02);

        // Randomized back-to-back ops
        for (int n = 0; n < 1000; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
